// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//
// MIPS instruction-fetch front end. This block owns the program counter and
// drives it straight into a combinational instruction memory. It captures the
// returned word into the IF/ID register together with its PC. It also handles
// stalls, branch/jump redirects, word alignment of redirect targets, and a
// halt instruction.
//
// Parameters:
//   RESET_PC   PC loaded on reset (bits [1:0] are forced to 00)
//   HALT_WORD  instruction word that stops fetching once captured
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   imem_addr        instruction memory address (always equals PC)
//   imem_rdata       instruction memory read data, combinational from imem_addr
//   stall            hold PC and IF/ID contents
//   redirect         branch/jump taken this cycle
//   redirect_target  new PC when redirect is high
//   if_instr         IF/ID instruction
//   if_pc            PC of if_instr
//   if_pc_plus4      if_pc + 4 (modulo 2^32)
//   if_valid         IF/ID holds a real instruction
//   halted           fetch stopped on HALT_WORD
//   misalign_err     sticky: a redirect target had bits [1:0] != 0
//   fetch_count      instructions captured into IF/ID
//
// Build option:
//   IFETCH_PERF_CNT_EN  when defined, fetch_count counts every normal capture
//                       (the HALT_WORD capture included) and wraps at 2^32.
//                       When undefined, fetch_count is tied to 0.
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Force the low bits of the reset vector to zero. This keeps the memory
    // word-aligned even if the parameter is misconfigured.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        capture;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;   // wraps naturally at 2^32

    // A normal capture happens only in RUN, when neither redirect nor stall
    // is active. Redirect takes priority over stall.
    assign capture = (state == RUN) && !redirect && !stall;

    // NOTE: all state here is clocked, so it uses non-blocking assignments.
    // Every register reads the pre-edge values of the others, which is what
    // the hardware does.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= BOOT;
            pc           <= RESET_PC_ALIGNED;
            if_instr     <= '0;
            if_pc        <= '0;
            if_pc_plus4  <= '0;
            if_valid     <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                // One idle cycle after reset. Stall and redirect are ignored.
                BOOT: begin
                    if_valid <= 1'b0;
                    state    <= RUN;
                end

                RUN: begin
                    if (redirect) begin
                        // The wrong-path fetch is dropped as a bubble. The
                        // IF/ID data fields keep their old values.
                        pc       <= {redirect_target[31:2], 2'b00};
                        if_valid <= 1'b0;
                        if (redirect_target[1:0] != 2'b00) begin
                            misalign_err <= 1'b1;
                        end
                    end else if (!stall) begin
                        if_instr    <= imem_rdata;
                        if_pc       <= pc;
                        if_pc_plus4 <= pc_plus4;
                        if_valid    <= 1'b1;
                        // The halt word is delivered downstream. The PC
                        // stays parked on its address.
                        if (imem_rdata == HALT_WORD) begin
                            state <= HALT;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end
                end

                // Terminal state. Only reset leaves it.
                HALT: begin
                    if_valid <= 1'b0;
                    halted   <= 1'b1;
                end

                default: state <= BOOT;
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (capture) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`else
    assign fetch_count = 32'd0;

    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. Each step drives the inputs for one
// clock edge and pushes the IF/ID snapshot expected after that edge onto a
// scoreboard queue. The snapshot is popped and compared just after the edge.
//
// A second instance with RESET_PC = 32'hFFFF_FFFC covers PC wrap-around.
// Both instances read from the same behavioural instruction memory.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

`ifdef IFETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [31:0] HALT_W = 32'hFC00_0000;
    localparam logic [31:0] WRAP_W = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] plus4;
        logic        valid;
        logic        halted;
        logic        mis;
        logic [31:0] addr;
        logic [31:0] count;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;

    logic [31:0] imem_addr,  imem_rdata;
    logic [31:0] if_instr,   if_pc,  if_pc_plus4, fetch_count;
    logic        if_valid,   halted, misalign_err;

    logic [31:0] w_addr,  w_rdata;
    logic [31:0] w_instr, w_pc,   w_plus4, w_count;
    logic        w_valid, w_halted, w_mis;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_no  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Instruction memory contents:
    //   address 12          -> halt word
    //   address 0xFFFF_FFFC -> WRAP_W
    //   any other address   -> 0xA000_0000 | address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_000C)      return HALT_W;
        else if (a == 32'hFFFF_FFFC) return WRAP_W;
        else                         return 32'hA000_0000 | a;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign w_rdata    = mem_word(w_addr);

    instruction_fetch u_dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .if_valid(if_valid), .halted(halted), .misalign_err(misalign_err),
        .fetch_count(fetch_count)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .if_instr(w_instr), .if_pc(w_pc), .if_pc_plus4(w_plus4),
        .if_valid(w_valid), .halted(w_halted), .misalign_err(w_mis),
        .fetch_count(w_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL step %0d %s: got %h expected %h", step_no, tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] plus4, input logic valid,
                                input logic hlt, input logic mis,
                                input logic [31:0] addr, input logic [31:0] cnt);
        exp_t e;
        e.instr  = instr;
        e.pc     = pc;
        e.plus4  = plus4;
        e.valid  = valid;
        e.halted = hlt;
        e.mis    = mis;
        e.addr   = addr;
        e.count  = PERF ? cnt : 32'd0;
        return e;
    endfunction

    // Drive one edge's inputs, push the expected result, clock, pop, compare.
    task automatic step(input logic rst, input logic st, input logic rd,
                        input logic [31:0] tgt, input exp_t e);
        exp_t got;
        reset           = rst;
        stall           = st;
        redirect        = rd;
        redirect_target = tgt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        n_checks++;
        assert (sb.size() != 0) n_pass++;
        else $error("FAIL step %0d scoreboard: got empty queue expected entry", step_no);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            chk("if_instr",     if_instr,              got.instr);
            chk("if_pc",        if_pc,                 got.pc);
            chk("if_pc_plus4",  if_pc_plus4,           got.plus4);
            chk("if_valid",     {31'd0, if_valid},     {31'd0, got.valid});
            chk("halted",       {31'd0, halted},       {31'd0, got.halted});
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, got.mis});
            chk("imem_addr",    imem_addr,             got.addr);
            chk("fetch_count",  fetch_count,           got.count);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;

        // Reset state.
        step(1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        chk("wrap reset addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap reset valid", {31'd0, w_valid}, 32'd0);

        // BOOT cycle: nothing is captured.
        step(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        chk("wrap boot valid", {31'd0, w_valid}, 32'd0);

        // Free run: addresses 0 and 4.
        step(0, 0, 0, 0, mk(32'hA000_0000, 0, 4, 1, 0, 0, 4, 1));
        chk("wrap pc0",    w_pc,    32'hFFFF_FFFC);
        chk("wrap instr0", w_instr, WRAP_W);
        chk("wrap plus4",  w_plus4, 32'h0000_0000);
        chk("wrap addr",   w_addr,  32'h0000_0000);
        step(0, 0, 0, 0, mk(32'hA000_0004, 4, 8, 1, 0, 0, 8, 2));
        chk("wrap pc1",    w_pc,    32'h0000_0000);
        chk("wrap instr1", w_instr, 32'hA000_0000);

        // Stall for three cycles while if_pc = 4.
        repeat (3) step(0, 1, 0, 0, mk(32'hA000_0004, 4, 8, 1, 0, 0, 8, 2));

        // Redirect to 0x40 with stall also high: one bubble, then 0x40.
        step(0, 1, 1, 32'h40, mk(32'hA000_0004, 4, 8, 0, 0, 0, 32'h40, 2));
        step(0, 0, 0, 0, mk(32'hA000_0040, 32'h40, 32'h44, 1, 0, 0, 32'h44, 3));

        // Misaligned redirect to 0x43: PC is aligned to 0x40, error is sticky.
        step(0, 0, 1, 32'h43, mk(32'hA000_0040, 32'h40, 32'h44, 0, 0, 1, 32'h40, 3));
        step(0, 0, 0, 0, mk(32'hA000_0040, 32'h40, 32'h44, 1, 0, 1, 32'h44, 4));
        step(0, 0, 1, 32'h8, mk(32'hA000_0040, 32'h40, 32'h44, 0, 0, 1, 32'h8, 4));
        step(0, 0, 0, 0, mk(32'hA000_0008, 32'h8, 32'hC, 1, 0, 1, 32'hC, 5));

        // Halt word at address 12: captured valid, then halted. Redirect and
        // stall are ignored after that.
        step(0, 0, 0, 0, mk(HALT_W, 32'hC, 32'h10, 1, 0, 1, 32'hC, 6));
        step(0, 1, 1, 32'h80, mk(HALT_W, 32'hC, 32'h10, 0, 1, 1, 32'hC, 6));
        step(0, 0, 1, 32'h0, mk(HALT_W, 32'hC, 32'h10, 0, 1, 1, 32'hC, 6));
        step(0, 0, 0, 0, mk(HALT_W, 32'hC, 32'h10, 0, 1, 1, 32'hC, 6));

        // Reset mid-run wins over redirect. Recovery is BOOT, then capture 0.
        step(1, 0, 1, 32'h40, mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, mk(32'hA000_0000, 0, 4, 1, 0, 0, 4, 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch front end of the single-cycle/pipelined MIPS datapath. Owns the program counter, drives the address into the combinational InstructionMemory (A -> RD), and captures the returned word into the IF/ID register with its PC. Handles stalls, branch/jump redirects, word alignment and a halt condition, so the memory only ever sees word-aligned addresses advancing by 4.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- HALT_WORD, 32'hFC00_0000: instruction word that stops fetching.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  32  address to InstructionMemory A; always equals PC.
- imem_rdata  input  32  InstructionMemory RD, combinational from imem_addr.
- stall  input  1  hold PC and IF/ID contents.
- redirect  input  1  branch/jump taken this cycle.
- redirect_target  input  32  new PC when redirect=1.
- if_instr  output  32  IF/ID instruction.
- if_pc  output  32  PC of if_instr.
- if_pc_plus4  output  32  if_pc + 4 (mod 2^32).
- if_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch stopped on HALT_WORD.
- misalign_err  output  1  sticky: a redirect target had bits [1:0] != 0.
- fetch_count  output  32  instructions captured into IF/ID (see Configuration).

## Operation
- States: BOOT, RUN, HALT.
- Reset (any state): PC=RESET_PC, state=BOOT, if_instr=0, if_pc=0, if_pc_plus4=0, if_valid=0, halted=0, misalign_err=0, fetch_count=0.
- BOOT: one cycle, no capture, if_valid=0; -> RUN unconditionally (stall and redirect ignored).
- RUN, priority per edge: redirect > stall > normal.
  - redirect: PC <= {redirect_target[31:2],2'b00}; if_valid <= 0 (bubble); IF/ID data unchanged; if target[1:0]!=0 set misalign_err.
  - stall (no redirect): PC and all IF/ID outputs hold.
  - normal: if_instr <= imem_rdata, if_pc <= PC, if_pc_plus4 <= PC+4, if_valid <= 1, fetch_count += 1; PC <= PC+4 unless imem_rdata == HALT_WORD.
  - Captured HALT_WORD: instruction is delivered with if_valid=1, PC holds, state -> HALT.
- HALT: halted=1; if_valid <= 0 on the first HALT edge and stays 0; PC and if_instr hold; stall/redirect ignored; exit only by reset.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- PC[1:0] is always 00 after reset if RESET_PC is aligned; RESET_PC[1:0] is forced to 00.
- misalign_err clears only on reset.

## Timing
- imem_addr is a direct register output; imem_rdata is sampled at the same clock edge that advances PC (zero added latency, one instruction per cycle).
- Instruction at address X appears on if_instr the edge after PC==X with no stall/redirect.
- Redirect costs exactly one bubble: target word appears on if_instr two edges after redirect is sampled.
- Stall asserted for N cycles freezes outputs N cycles; first capture follows the first edge with stall=0.
- reset asserted mid-run wins over every input on that edge; first valid instruction (RESET_PC) appears two edges after reset deasserts (BOOT then capture).

## Configuration
- IFETCH_PERF_CNT_EN defined: fetch_count increments on every normal capture (including the HALT_WORD capture), wraps at 2^32.
- Not defined: counter logic is omitted; fetch_count is constant 0.

## Test plan
- Reset then free-run with memory words W0,W1,W2 at 0,4,8 -> if_instr=W0,W1,W2 on consecutive cycles, if_pc=0,4,8, if_pc_plus4=4,8,12, fetch_count=3 (with macro).
- Stall high 3 cycles while if_pc=4 -> imem_addr stays 8, if_instr/if_pc frozen 3 cycles, next capture if_pc=8.
- Redirect to 32'h40 at PC=8 with stall also high -> one if_valid=0 cycle, then if_pc=32'h40; misalign_err=0.
- Redirect to 32'h43 -> PC becomes 32'h40, misalign_err=1 and stays 1 until reset.
- Word at 12 = 32'hFC00_0000 -> captured with if_valid=1, next cycle halted=1, if_valid=0, imem_addr held at 12; redirect ignored.
- RESET_PC=32'hFFFF_FFFC -> if_pc=FFFF_FFFC then 0000_0000; reset asserted mid-sequence -> all outputs return to reset values next edge.
